mod_adder_ctrl: RTL and testbench

Sequencer that computes modular sums and differences, (a ± b) mod M, on 512-bit operands by driving one instance of the team's multi-precision `adder` twice per operation. The first pass computes the raw sum or difference; the second pass applies the modulus correction. The block sits between the higher-level crypto datapath (for example a Montgomery/exponentiation FSM) and the adder, and owns the adder's start/subtract/operand pins exclusively.

---
 rtl/mod_adder_ctrl.sv | 145 ++++++++++++++
 tb/tb_mod_adder_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_adder_ctrl.sv
// mod_adder_ctrl: (a +/- b) mod M sequencer driving one multi-precision adder.
// Pass 1 issues the raw a +/- b, pass 2 applies the modulus correction
// (subtract M after an add, add M back after a subtract) and the sign of the
// appropriate pass selects the final value. Both passes always run, so the
// latency is data independent.
// Optional feature: define MODADD_TIMEOUT_EN to add a per-WAIT-state watchdog
// of TIMEOUT cycles and the sticky `error` output.
module mod_adder_ctrl #(
  parameter int N       = 512,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         subtract,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] modulus,
  output logic         busy,
  output logic [N-1:0] result,
  output logic         done,
`ifdef MODADD_TIMEOUT_EN
  output logic         error,
`endif
  output logic         add_start,
  output logic         add_subtract,
  output logic [N:0]   add_in_a,
  output logic [N:0]   add_in_b,
  input  logic [N+1:0] add_result,
  input  logic         add_done
);

  typedef enum logic [2:0] {
    IDLE, OP1_GO, OP1_WAIT, OP2_GO, OP2_WAIT, FINISH
  } state_t;

  state_t       state;
  logic         op;      // latched subtract select
  logic [N-1:0] m_q;     // latched modulus
  // First-pass result. Bit N travels straight into the second-pass operand,
  // so only the sign and the low N bits need to be kept here.
  logic         s_neg;
  logic [N-1:0] s_lo;

`ifdef MODADD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] wait_cnt;
`endif

  // Sequencer: one pass per GO/WAIT pair; every output is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op           <= 1'b0;
      m_q          <= '0;
      s_neg        <= 1'b0;
      s_lo         <= '0;
      busy         <= 1'b0;
      result       <= '0;
      done         <= 1'b0;
      add_start    <= 1'b0;
      add_subtract <= 1'b0;
      add_in_a     <= '0;
      add_in_b     <= '0;
`ifdef MODADD_TIMEOUT_EN
      error        <= 1'b0;
      wait_cnt     <= '0;
`endif
    end else begin
      add_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Operands go straight into the adder drive registers, which
            // then hold a and b for the whole first pass.
            op           <= subtract;
            m_q          <= modulus;
            add_in_a     <= {1'b0, in_a};
            add_in_b     <= {1'b0, in_b};
            add_subtract <= subtract;
            add_start    <= 1'b1;
            busy         <= 1'b1;
            state        <= OP1_GO;
`ifdef MODADD_TIMEOUT_EN
            error        <= 1'b0;
`endif
          end
        end
        OP1_GO: state <= OP1_WAIT;
        OP1_WAIT: begin
          if (add_done) begin
            s_neg        <= add_result[N+1];
            s_lo         <= add_result[N-1:0];
            // Correction pass: s - M after an add, s + M after a subtract.
            add_in_a     <= add_result[N:0];
            add_in_b     <= {1'b0, m_q};
            add_subtract <= ~op;
            add_start    <= 1'b1;
            state        <= OP2_GO;
          end
`ifdef MODADD_TIMEOUT_EN
          else if (wait_cnt == TLAST) begin
            result <= '0;
            error  <= 1'b1;
            done   <= 1'b1;
            state  <= FINISH;
          end
`endif
        end
        OP2_GO: state <= OP2_WAIT;
        OP2_WAIT: begin
          if (add_done) begin
            if (!op) result <= add_result[N+1] ? s_lo : add_result[N-1:0];
            else     result <= s_neg ? add_result[N-1:0] : s_lo;
            done  <= 1'b1;
            state <= FINISH;
          end
`ifdef MODADD_TIMEOUT_EN
          else if (wait_cnt == TLAST) begin
            result <= '0;
            error  <= 1'b1;
            done   <= 1'b1;
            state  <= FINISH;
          end
`endif
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef MODADD_TIMEOUT_EN
      // Watchdog counts idle WAIT cycles; any add_done or state exit clears it.
      if ((state == OP1_WAIT || state == OP2_WAIT) && !add_done && wait_cnt != TLAST)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_mod_adder_ctrl.sv
// Bench for mod_adder_ctrl: behavioural adder stub with programmable latency,
// scoreboard queue of expected results, one task per scenario.
module tb_mod_adder_ctrl;
  localparam int N = 512;
`ifdef MODADD_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1023;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         subtract = 1'b0;
  logic [N-1:0] in_a = '0, in_b = '0, modulus = '0;
  logic         busy, done;
  logic [N-1:0] result;
`ifdef MODADD_TIMEOUT_EN
  logic         error;
`endif
  logic         add_start, add_subtract;
  logic [N:0]   add_in_a, add_in_b;
  logic [N+1:0] add_result = '0;
  logic         add_done = 1'b0;

  int nvec = 0, nmis = 0;
  int cyc = 0, t0 = 0;
  int lat = 3;
  bit hang = 0;
  logic [N-1:0] exp_q[$];

  mod_adder_ctrl #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .modulus(modulus),
    .busy(busy), .result(result), .done(done),
`ifdef MODADD_TIMEOUT_EN
    .error(error),
`endif
    .add_start(add_start), .add_subtract(add_subtract),
    .add_in_a(add_in_a), .add_in_b(add_in_b),
    .add_result(add_result), .add_done(add_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder stub: add_done arrives `lat` cycles after add_start (lat >= 2).
  int cd = 0;
  bit pend = 0;
  always @(posedge clk) begin
    add_done <= 1'b0;
    if (reset) begin
      pend <= 0; cd <= 0;
    end else if (add_start) begin
      pend <= 1; cd <= lat - 1;
      add_result <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                 : ({1'b0, add_in_a} + {1'b0, add_in_b});
    end else if (pend && !hang) begin
      if (cd <= 1) begin add_done <= 1'b1; pend <= 0; end
      else cd <= cd - 1;
    end
  end

  function automatic logic [N-1:0] model(input logic [N-1:0] a, b, m, input logic sub);
    logic [N+1:0] t;
    if (!sub) begin
      t = {2'b0, a} + {2'b0, b};
      if (t >= {2'b0, m}) t = t - {2'b0, m};
    end else if (a >= b) t = {2'b0, a} - {2'b0, b};
    else t = {2'b0, a} + {2'b0, m} - {2'b0, b};
    return t[N-1:0];
  endfunction

  task automatic issue(input logic [N-1:0] a, b, m, input logic sub, input bit push,
                       input logic [N-1:0] e);
    @(negedge clk);
    in_a = a; in_b = b; modulus = m; subtract = sub; start = 1'b1; t0 = cyc;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    in_a = {16{$urandom()}}; in_b = {16{$urandom()}}; modulus = {16{$urandom()}};
    subtract = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int limit, output bit got, output int rel);
    got = 0; rel = -1;
    for (int i = 0; i < limit && !got; i++) begin
      if (done === 1'b1) begin got = 1; rel = cyc - t0; end
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL reset_busy: got %0b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nmis++; $display("FAIL reset_done: got %0b want 0", done); end
    nvec++; if (result !== '0) begin nmis++; $display("FAIL reset_result: got %0h want 0", result); end
    nvec++; if (add_start !== 1'b0) begin nmis++; $display("FAIL reset_add_start: got %0b want 0", add_start); end
    nvec++; if (add_subtract !== 1'b0) begin nmis++; $display("FAIL reset_add_subtract: got %0b want 0", add_subtract); end
    nvec++; if (add_in_a !== '0 || add_in_b !== '0) begin nmis++; $display("FAIL reset_add_in: got %0h/%0h want 0", add_in_a, add_in_b); end
`ifdef MODADD_TIMEOUT_EN
    nvec++; if (error !== 1'b0) begin nmis++; $display("FAIL reset_error: got %0b want 0", error); end
`endif
  endtask

  task automatic test_basic;
    bit got; int rel; logic [N-1:0] e;
    lat = 3;
    issue(N'(1), N'(1), N'(5), 1'b0, 1, N'(2));
    wait_done(60, got, rel);
    nvec++;
    if (!got) begin nmis++; $display("FAIL basic_done: got no done want done"); end
    else begin
      e = exp_q.pop_front();
      if (result !== e) begin nmis++; $display("FAIL basic_result: got %0h want %0h", result, e); end
      nvec++; if (busy !== 1'b1) begin nmis++; $display("FAIL basic_busy_at_done: got %0b want 1", busy); end
      @(negedge clk);
      nvec++; if (busy !== 1'b0 || done !== 1'b0) begin nmis++; $display("FAIL basic_after: got busy=%0b done=%0b want 0/0", busy, done); end
    end
  endtask

  task automatic test_mod5;
    int ta[6] = '{3, 2, 2, 4, 0, 4};
    int tb[6] = '{4, 3, 3, 4, 4, 0};
    int ts[6] = '{0, 0, 1, 1, 1, 1};
    int te[6] = '{2, 0, 4, 0, 1, 4};
    bit got; int rel; logic [N-1:0] e;
    for (int i = 0; i < 6; i++) begin
      lat = $urandom_range(2, 5);
      issue(N'(ta[i]), N'(tb[i]), N'(5), 1'(ts[i]), 1, N'(te[i]));
      wait_done(60, got, rel);
      nvec++;
      if (!got) begin nmis++; $display("FAIL mod5_%0d_done: got no done want done", i); end
      else begin
        e = exp_q.pop_front();
        if (result !== e) begin nmis++; $display("FAIL mod5_%0d: got %0h want %0h", i, result, e); end
      end
    end
  endtask

  task automatic test_big;
    logic [N-1:0] m, a, b, e, one;
    bit got; int rel; logic sub;
    m = '1; m = m - N'(568); one = N'(1);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin a = m - one; b = m - one; sub = 0; e = m - N'(2); end
      else if (i == 1) begin a = '0; b = m - one; sub = 1; e = one; end
      else begin
        a = {16{$urandom()}}; if (a >= m) a = a - m;
        b = {16{$urandom()}}; if (b >= m) b = b - m;
        sub = 1'(i & 1); e = model(a, b, m, sub);
      end
      lat = $urandom_range(2, 4);
      issue(a, b, m, sub, 1, e);
      wait_done(60, got, rel);
      nvec++;
      if (!got) begin nmis++; $display("FAIL big_%0d_done: got no done want done", i); end
      else begin
        e = exp_q.pop_front();
        if (result !== e) begin nmis++; $display("FAIL big_%0d: got %0h want %0h", i, result, e); end
      end
    end
  endtask

  task automatic test_timing;
    int r, ns, s1, s2, nd, dr; logic [N-1:0] e;
    lat = 3; ns = 0; nd = 0; s1 = -1; s2 = -1; dr = -1;
    @(negedge clk);
    in_a = N'(3); in_b = N'(4); modulus = N'(5); subtract = 1'b0; start = 1'b1; t0 = cyc;
    exp_q.push_back(N'(2));
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      r = cyc - t0;
      if (add_start === 1'b1) begin
        if (ns == 0) s1 = r; else if (ns == 1) s2 = r;
        ns++;
      end
      if (done === 1'b1) begin
        nd++; dr = r;
        nvec++;
        if (exp_q.size() == 0) begin nmis++; $display("FAIL timing_extra_done: got done at %0d want none", r); end
        else begin
          e = exp_q.pop_front();
          if (result !== e) begin nmis++; $display("FAIL timing_result: got %0h want %0h", result, e); end
        end
      end
      if (r == 10) begin
        nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL timing_busy_c10: got %0b want 0", busy); end
      end
      start = (r >= 2 && r <= 8);
      in_a = N'($urandom_range(0, 4)); in_b = N'($urandom_range(0, 4));
      subtract = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    nvec++; if (s1 != 1) begin nmis++; $display("FAIL timing_start1: got %0d want 1", s1); end
    nvec++; if (s2 != 5) begin nmis++; $display("FAIL timing_start2: got %0d want 5", s2); end
    nvec++; if (ns != 2) begin nmis++; $display("FAIL timing_nstart: got %0d want 2", ns); end
    nvec++; if (nd != 1) begin nmis++; $display("FAIL timing_ndone: got %0d want 1", nd); end
    nvec++; if (dr != 9) begin nmis++; $display("FAIL timing_done_cycle: got %0d want 9", dr); end
  endtask

  task automatic test_reset_mid;
    int nd; bit got; int rel; logic [N-1:0] e;
    lat = 3; nd = 0;
    issue(N'(1), N'(1), N'(5), 1'b0, 0, '0);
    repeat (5) @(negedge clk);
    nvec++; if (busy !== 1'b1) begin nmis++; $display("FAIL rmid_busy_before: got %0b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) nd++;
      @(negedge clk);
    end
    nvec++; if (nd != 0) begin nmis++; $display("FAIL rmid_done: got %0d pulses want 0", nd); end
    nvec++;
    if (busy !== 1'b0 || result !== '0 || add_start !== 1'b0 || add_subtract !== 1'b0 ||
        add_in_a !== '0 || add_in_b !== '0) begin
      nmis++; $display("FAIL rmid_outputs: got busy=%0b result=%0h add_in_a=%0h want all 0", busy, result, add_in_a);
    end
    issue(N'(1), N'(1), N'(5), 1'b0, 1, N'(2));
    wait_done(60, got, rel);
    nvec++;
    if (!got) begin nmis++; $display("FAIL rmid_after_done: got no done want done"); end
    else begin
      e = exp_q.pop_front();
      if (result !== e) begin nmis++; $display("FAIL rmid_after: got %0h want %0h", result, e); end
    end
  endtask

`ifdef MODADD_TIMEOUT_EN
  task automatic test_timeout;
    bit got; int rel; logic [N-1:0] e;
    lat = 3; hang = 1;
    issue(N'(3), N'(4), N'(5), 1'b0, 0, '0);
    wait_done(80, got, rel);
    nvec++;
    if (!got) begin nmis++; $display("FAIL to_done: got no done want done"); end
    else begin
      if (rel != 18) begin nmis++; $display("FAIL to_cycle: got %0d want 18", rel); end
      nvec++; if (error !== 1'b1) begin nmis++; $display("FAIL to_error: got %0b want 1", error); end
      nvec++; if (result !== '0) begin nmis++; $display("FAIL to_result: got %0h want 0", result); end
    end
    @(negedge clk);
    hang = 0;
    nvec++; if (error !== 1'b1) begin nmis++; $display("FAIL to_error_held: got %0b want 1", error); end
    issue(N'(3), N'(4), N'(5), 1'b0, 1, N'(2));
    nvec++; if (error !== 1'b0) begin nmis++; $display("FAIL to_error_clear: got %0b want 0", error); end
    wait_done(60, got, rel);
    nvec++;
    if (!got) begin nmis++; $display("FAIL to_good_done: got no done want done"); end
    else begin
      e = exp_q.pop_front();
      if (result !== e) begin nmis++; $display("FAIL to_good: got %0h want %0h", result, e); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_mod5;
    test_big;
    test_timing;
    test_reset_mid;
`ifdef MODADD_TIMEOUT_EN
    test_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
